spike_commit_scheduler: RTL and testbench
=========================================

# spike_commit_scheduler

Multi-hart commit scheduler for the Spike co-simulation harness. Collects per-hart retirement events into small per-hart FIFOs and shares the single, serialized reference-model checker port between harts with round-robin arbitration. Exactly one step is outstanding at a time, matching the blocking step/compare call made by the checker. Sits between the core commit taps and the DPI-side checker; halts issuing on the first mismatch or checker timeout.

## Interface
Parameters:
- NUM_HARTS, 4, number of harts (≥1)
- FIFO_DEPTH, 4, entries per hart FIFO (power of 2, ≥2)
- TIMEOUT, 1024, max cycles in WAIT before timeout error; 0 disables
- HW, $clog2(NUM_HARTS) (min 1), hart index width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- commit_valid  in  NUM_HARTS  per-hart retirement strobe
- commit_ready  out  NUM_HARTS  per-hart FIFO not full
- commit_pc  in  NUM_HARTS*64  retired PC, hart h at [h*64+:64]
- commit_ins  in  NUM_HARTS*32  instruction word
- commit_wr_valid  in  NUM_HARTS  register write performed
- commit_dst  in  NUM_HARTS*5  destination register
- commit_data  in  NUM_HARTS*64  write-back data
- chk_req_valid  out  1  step request to checker
- chk_req_ready  in  1  checker accepts request
- chk_req_hart  out  HW  hart to step
- chk_req_pc / chk_req_ins / chk_req_wr_valid / chk_req_dst / chk_req_data  out  64/32/1/5/64  latched commit record
- chk_done_valid  in  1  checker finished comparison
- chk_done_mismatch  in  1  comparison failed (valid with chk_done_valid)
- err  out  1  sticky: mismatch or timeout
- err_timeout  out  1  sticky: error cause was timeout
- err_hart  out  HW  hart of failing step
- commit_cnt  out  32  successfully checked commits (wraps)
- busy  out  1  state ≠ IDLE or any FIFO non-empty

## Operation
- Per-hart FIFO: push when commit_valid[h] & commit_ready[h]; commit_ready[h] = !full[h] (no push-through when full, even if popping same cycle). commit_valid while not ready is dropped; not an error.
- FSM states IDLE, ISSUE, WAIT, HALT.
- IDLE: if any FIFO non-empty, grant first non-empty hart searching from (last_grant+1) mod NUM_HARTS upward with wrap; pop it, latch record and hart into chk_req_*, update last_grant, → ISSUE. Otherwise stay.
- ISSUE: chk_req_valid=1, chk_req_* stable. On chk_req_ready → WAIT.
- WAIT: timeout counter increments each cycle. On chk_done_valid: if mismatch → set err, err_hart=chk_req_hart, → HALT; else commit_cnt+1, → IDLE. If TIMEOUT≠0 and counter reaches TIMEOUT without done → err, err_timeout, err_hart, → HALT. Done on the same cycle as the limit wins (treated as done).
- HALT: terminal until rst; no issues; FIFOs keep accepting until full, then commit_ready deasserts.
- chk_done_valid outside WAIT is ignored.
- last_grant resets to NUM_HARTS-1 so hart 0 has first priority.

## Timing
- Reset values: chk_req_valid 0, all chk_req_* 0, err 0, err_timeout 0, err_hart 0, commit_cnt 0, busy 0, commit_ready all 1, FSM IDLE, FIFOs empty, timeout counter 0.
- Commit pushed at cycle t → visible in FIFO at t+1 → popped in IDLE at t+1 → chk_req_valid at t+2.
- Minimum per-step occupancy 3 cycles (IDLE, ISSUE with ready, WAIT with done) → max throughput 1 commit / 3 cycles.
- Timeout counter cleared on WAIT entry; err asserts the cycle after the TIMEOUT-th WAIT cycle.
- rst in any state (including mid-WAIT) returns to reset values next edge; FIFO contents discarded; a late chk_done_valid after reset is ignored.

## Test plan
- Single commit hart 2 (pc=0x80000000, ins=0x00000013) at t=0, ready=1, done at t+3 no mismatch → chk_req_valid t+2 with hart=2, commit_cnt=1, busy low after return to IDLE.
- Harts 0,1,3 commit same cycle, then hart 0 again → steps issued in order 0,1,3,0; commit_cnt=4.
- Hold chk_req_ready=0, push 5 commits on hart 1 (FIFO_DEPTH=4) → commit_ready[1] low after 5th enter (4 queued + 1 latched), 6th dropped; release → exactly 5 checked.
- Mismatch on 2nd step (hart 3) → err=1, err_hart=3, err_timeout=0, commit_cnt=1, no further chk_req_valid while FIFOs hold data.
- TIMEOUT=16, never assert done → err=1, err_timeout=1 after 16 WAIT cycles; state HALT.
- rst asserted mid-WAIT with 3 queued entries → all outputs at reset values next cycle, FIFOs empty, stray done ignored.

Source files
------------

// File: rtl/spike_commit_scheduler.sv
// Commit scheduler: per-hart retirement FIFOs feeding one serialized checker port
// through a round-robin arbiter, with sticky mismatch/timeout halt.
module spike_commit_scheduler #(
    parameter int NUM_HARTS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024,
    parameter int HW         = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_HARTS-1:0]      commit_valid,
    output logic [NUM_HARTS-1:0]      commit_ready,
    input  logic [NUM_HARTS*64-1:0]   commit_pc,
    input  logic [NUM_HARTS*32-1:0]   commit_ins,
    input  logic [NUM_HARTS-1:0]      commit_wr_valid,
    input  logic [NUM_HARTS*5-1:0]    commit_dst,
    input  logic [NUM_HARTS*64-1:0]   commit_data,
    output logic                      chk_req_valid,
    input  logic                      chk_req_ready,
    output logic [HW-1:0]             chk_req_hart,
    output logic [63:0]               chk_req_pc,
    output logic [31:0]               chk_req_ins,
    output logic                      chk_req_wr_valid,
    output logic [4:0]                chk_req_dst,
    output logic [63:0]               chk_req_data,
    input  logic                      chk_done_valid,
    input  logic                      chk_done_mismatch,
    output logic                      err,
    output logic                      err_timeout,
    output logic [HW-1:0]             err_hart,
    output logic [31:0]               commit_cnt,
    output logic                      busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RW = 64 + 32 + 1 + 5 + 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [RW-1:0]       r_mem [NUM_HARTS][FIFO_DEPTH];
    logic [AW:0]         r_wptr [NUM_HARTS];
    logic [AW:0]         r_rptr [NUM_HARTS];
    logic [NUM_HARTS-1:0] w_empty;
    logic [NUM_HARTS-1:0] w_full;
    logic [NUM_HARTS-1:0] w_push;
    logic [NUM_HARTS-1:0] w_pop;
    logic [RW-1:0]       w_push_rec [NUM_HARTS];
    logic [RW-1:0]       w_head_rec;
    logic [HW-1:0]       r_last_grant;
    logic [HW-1:0]       w_grant_hart;
    logic [HW-1:0]       w_cand;
    logic                w_any;
    int                  w_idx;
    logic                w_grant_en;
    logic                w_done_ok;
    logic                w_fail;
    logic                w_tmo;
    logic [31:0]         r_tmo_cnt;

    logic                r_req_wr_valid;
    logic [HW-1:0]       r_req_hart;
    logic [63:0]         r_req_pc;
    logic [31:0]         r_req_ins;
    logic [4:0]          r_req_dst;
    logic [63:0]         r_req_data;
    logic                r_err;
    logic                r_err_timeout;
    logic [HW-1:0]       r_err_hart;
    logic [31:0]         r_commit_cnt;

    // FIFO status flags and packed push records per hart
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_empty[h]    = (r_wptr[h] == r_rptr[h]);
            w_full[h]     = (r_wptr[h][AW-1:0] == r_rptr[h][AW-1:0]) &&
                            (r_wptr[h][AW] != r_rptr[h][AW]);
            w_push[h]     = commit_valid[h] & ~w_full[h];
            w_pop[h]      = w_grant_en && (w_grant_hart == HW'(h));
            w_push_rec[h] = {commit_pc[h*64 +: 64], commit_ins[h*32 +: 32],
                             commit_wr_valid[h], commit_dst[h*5 +: 5],
                             commit_data[h*64 +: 64]};
        end
    end

    // Round-robin search starting just after the last granted hart
    always_comb begin
        w_any        = 1'b0;
        w_grant_hart = '0;
        w_idx        = 0;
        w_cand       = '0;
        for (int k = 1; k <= NUM_HARTS; k++) begin
            w_idx  = (int'(r_last_grant) + k) % NUM_HARTS;
            w_cand = HW'(w_idx);
            if (!w_any && !w_empty[w_cand]) begin
                w_any        = 1'b1;
                w_grant_hart = w_cand;
            end else begin
                w_any        = w_any;
            end
        end
        w_head_rec = r_mem[w_grant_hart][r_rptr[w_grant_hart][AW-1:0]];
    end

    // Next-state logic; a done arriving on the limit cycle takes priority over timeout
    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_done_ok   = 1'b0;
        w_fail      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (chk_req_ready) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (chk_done_valid) begin
                    if (chk_done_mismatch) begin
                        w_fail      = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_done_ok   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if ((TIMEOUT != 0) && (r_tmo_cnt == 32'(TIMEOUT - 1))) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_push[h]) begin
                r_mem[h][r_wptr[h][AW-1:0]] <= w_push_rec[h];
            end
        end
    end

    // FIFO pointers, request latch, timeout counter, error and commit counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_wptr[h] <= '0;
                r_rptr[h] <= '0;
            end
            r_last_grant   <= HW'(NUM_HARTS - 1);
            r_req_hart     <= '0;
            r_req_pc       <= 64'd0;
            r_req_ins      <= 32'd0;
            r_req_wr_valid <= 1'b0;
            r_req_dst      <= 5'd0;
            r_req_data     <= 64'd0;
            r_tmo_cnt      <= 32'd0;
            r_err          <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_hart     <= '0;
            r_commit_cnt   <= 32'd0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (w_push[h]) begin
                    r_wptr[h] <= r_wptr[h] + {{AW{1'b0}}, 1'b1};
                end
                if (w_pop[h]) begin
                    r_rptr[h] <= r_rptr[h] + {{AW{1'b0}}, 1'b1};
                end
            end
            if (w_grant_en) begin
                r_last_grant <= w_grant_hart;
                r_req_hart   <= w_grant_hart;
                {r_req_pc, r_req_ins, r_req_wr_valid, r_req_dst, r_req_data} <= w_head_rec;
            end
            if ((r_state == S_ISSUE) && chk_req_ready) begin
                r_tmo_cnt <= 32'd0;
            end else if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 32'd1;
            end
            if (w_done_ok) begin
                r_commit_cnt <= r_commit_cnt + 32'd1;
            end
            if (w_fail || w_tmo) begin
                r_err         <= 1'b1;
                r_err_timeout <= w_tmo;
                r_err_hart    <= r_req_hart;
            end
        end
    end

    assign commit_ready     = ~w_full;
    assign chk_req_valid    = (r_state == S_ISSUE);
    assign chk_req_hart     = r_req_hart;
    assign chk_req_pc       = r_req_pc;
    assign chk_req_ins      = r_req_ins;
    assign chk_req_wr_valid = r_req_wr_valid;
    assign chk_req_dst      = r_req_dst;
    assign chk_req_data     = r_req_data;
    assign err              = r_err;
    assign err_timeout      = r_err_timeout;
    assign err_hart         = r_err_hart;
    assign commit_cnt       = r_commit_cnt;
    assign busy             = (r_state != S_IDLE) || !(&w_empty);

endmodule

// File: tb/tb_spike_commit_scheduler.sv
// Directed bench for spike_commit_scheduler: a cycle table for the single-commit
// path plus hand-written sequences for arbitration, backpressure, errors and reset.
module tb_spike_commit_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   commit_valid;
    logic [3:0]   commit_ready;
    logic [255:0] commit_pc;
    logic [127:0] commit_ins;
    logic [3:0]   commit_wr_valid;
    logic [19:0]  commit_dst;
    logic [255:0] commit_data;
    logic         chk_req_valid;
    logic         chk_req_ready;
    logic [1:0]   chk_req_hart;
    logic [63:0]  chk_req_pc;
    logic [31:0]  chk_req_ins;
    logic         chk_req_wr_valid;
    logic [4:0]   chk_req_dst;
    logic [63:0]  chk_req_data;
    logic         chk_done_valid;
    logic         chk_done_mismatch;
    logic         err;
    logic         err_timeout;
    logic [1:0]   err_hart;
    logic [31:0]  commit_cnt;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    spike_commit_scheduler #(.NUM_HARTS(4), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_pc(commit_pc), .commit_ins(commit_ins),
        .commit_wr_valid(commit_wr_valid), .commit_dst(commit_dst),
        .commit_data(commit_data),
        .chk_req_valid(chk_req_valid), .chk_req_ready(chk_req_ready),
        .chk_req_hart(chk_req_hart), .chk_req_pc(chk_req_pc),
        .chk_req_ins(chk_req_ins), .chk_req_wr_valid(chk_req_wr_valid),
        .chk_req_dst(chk_req_dst), .chk_req_data(chk_req_data),
        .chk_done_valid(chk_done_valid), .chk_done_mismatch(chk_done_mismatch),
        .err(err), .err_timeout(err_timeout), .err_hart(err_hart),
        .commit_cnt(commit_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cv;
        logic        rdy;
        logic        dv;
        logic        e_valid;
        logic [1:0]  e_hart;
        logic [31:0] e_cnt;
        logic        e_busy;
        logic        e_err;
        logic [3:0]  e_ready;
    } vec_t;

    vec_t tbl [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        commit_valid = 4'd0;
        chk_req_ready = 1'b0;
        chk_done_valid = 1'b0;
        chk_done_mismatch = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drive one cycle of commits; lane h gets pc = base + 16*h
    task automatic push(input logic [3:0] m, input logic [63:0] base);
        commit_valid = m;
        for (int h = 0; h < 4; h++) begin
            commit_pc[h*64 +: 64]  = base + 64'(h * 16);
            commit_ins[h*32 +: 32] = 32'h0000_0013 + 32'(h);
            commit_data[h*64 +: 64] = base ^ 64'hFFFF_0000;
            commit_dst[h*5 +: 5]   = 5'(h + 1);
        end
        commit_wr_valid = 4'hF;
        tick();
        commit_valid = 4'd0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!chk_req_valid && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_req_seen"}, 64'(chk_req_valid), 64'd1);
    endtask

    // Act as the checker for one step: accept, then answer done next cycle
    task automatic serve(input string name, input logic [1:0] hart, input logic [63:0] pc, input logic mism);
        wait_req(name);
        chk({name, "_hart"}, 64'(chk_req_hart), 64'(hart));
        chk({name, "_pc"}, chk_req_pc, pc);
        chk_req_ready = 1'b1;
        tick();
        chk_req_ready = 1'b0;
        chk_done_valid = 1'b1;
        chk_done_mismatch = mism;
        tick();
        chk_done_valid = 1'b0;
        chk_done_mismatch = 1'b0;
    endtask

    initial begin
        int seen;
        commit_pc = '0; commit_ins = '0; commit_wr_valid = '0;
        commit_dst = '0; commit_data = '0;

        do_reset();
        chk("rst_req_valid", 64'(chk_req_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cnt", 64'(commit_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(commit_ready), 64'hF);

        // Single commit on hart 2: request at t+2, done at t+3
        tbl[0] = '{cv: 4'b0100, rdy: 1'b0, dv: 1'b0, e_valid: 1'b0, e_hart: 2'd0, e_cnt: 32'd0, e_busy: 1'b1, e_err: 1'b0, e_ready: 4'hF};
        tbl[1] = '{cv: 4'b0000, rdy: 1'b1, dv: 1'b0, e_valid: 1'b1, e_hart: 2'd2, e_cnt: 32'd0, e_busy: 1'b1, e_err: 1'b0, e_ready: 4'hF};
        tbl[2] = '{cv: 4'b0000, rdy: 1'b1, dv: 1'b0, e_valid: 1'b0, e_hart: 2'd2, e_cnt: 32'd0, e_busy: 1'b1, e_err: 1'b0, e_ready: 4'hF};
        tbl[3] = '{cv: 4'b0000, rdy: 1'b0, dv: 1'b1, e_valid: 1'b0, e_hart: 2'd2, e_cnt: 32'd1, e_busy: 1'b0, e_err: 1'b0, e_ready: 4'hF};
        tbl[4] = '{cv: 4'b0000, rdy: 1'b0, dv: 1'b1, e_valid: 1'b0, e_hart: 2'd2, e_cnt: 32'd1, e_busy: 1'b0, e_err: 1'b0, e_ready: 4'hF};
        commit_pc = {4{64'h0000_0000_8000_0000}};
        commit_ins = {4{32'h0000_0013}};
        for (int i = 0; i < 5; i++) begin
            commit_valid = tbl[i].cv;
            chk_req_ready = tbl[i].rdy;
            chk_done_valid = tbl[i].dv;
            tick();
            chk($sformatf("t1_r%0d_valid", i), 64'(chk_req_valid), 64'(tbl[i].e_valid));
            chk($sformatf("t1_r%0d_hart", i), 64'(chk_req_hart), 64'(tbl[i].e_hart));
            chk($sformatf("t1_r%0d_cnt", i), 64'(commit_cnt), 64'(tbl[i].e_cnt));
            chk($sformatf("t1_r%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("t1_r%0d_err", i), 64'(err), 64'(tbl[i].e_err));
            chk($sformatf("t1_r%0d_ready", i), 64'(commit_ready), 64'(tbl[i].e_ready));
            if (i == 1) begin
                chk("t1_pc", chk_req_pc, 64'h8000_0000);
                chk("t1_ins", 64'(chk_req_ins), 64'h13);
            end
        end
        commit_valid = 4'd0; chk_req_ready = 1'b0; chk_done_valid = 1'b0;

        // Round-robin order 0,1,3,0
        do_reset();
        push(4'b1011, 64'h1000);
        push(4'b0001, 64'h1100);
        serve("rr0", 2'd0, 64'h1000, 1'b0);
        serve("rr1", 2'd1, 64'h1010, 1'b0);
        serve("rr3", 2'd3, 64'h1030, 1'b0);
        serve("rr0b", 2'd0, 64'h1100, 1'b0);
        chk("rr_cnt", 64'(commit_cnt), 64'd4);
        chk("rr_busy", 64'(busy), 64'd0);

        // Backpressure: 4 queued + 1 latched, 6th dropped
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push(4'b0010, 64'h2000 + 64'(k * 256));
            chk($sformatf("bp_ready_after_%0d", k + 1), 64'(commit_ready[1]), (k == 4) ? 64'd0 : 64'd1);
        end
        push(4'b0010, 64'h2500);
        chk("bp_ready_6th", 64'(commit_ready[1]), 64'd0);
        for (int k = 0; k < 5; k++) begin
            serve($sformatf("bp%0d", k), 2'd1, 64'h2010 + 64'(k * 256), 1'b0);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (chk_req_valid) seen++;
        end
        chk("bp_no_6th", 64'(seen), 64'd0);
        chk("bp_cnt", 64'(commit_cnt), 64'd5);

        // Mismatch on second step halts with data still queued
        do_reset();
        push(4'b1001, 64'h3000);
        push(4'b1000, 64'h3100);
        serve("mm0", 2'd0, 64'h3000, 1'b0);
        serve("mm3", 2'd3, 64'h3030, 1'b1);
        chk("mm_err", 64'(err), 64'd1);
        chk("mm_err_hart", 64'(err_hart), 64'd3);
        chk("mm_err_timeout", 64'(err_timeout), 64'd0);
        chk("mm_cnt", 64'(commit_cnt), 64'd1);
        for (int k = 0; k < 4; k++) begin
            push(4'b0100, 64'h3200);
        end
        chk("mm_halt_fill_ready2", 64'(commit_ready[2]), 64'd0);
        chk("mm_halt_ready3", 64'(commit_ready[3]), 64'd1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (chk_req_valid) seen++;
        end
        chk("mm_no_issue", 64'(seen), 64'd0);
        chk("mm_busy", 64'(busy), 64'd1);

        // Done on the 16th WAIT cycle beats the timeout
        do_reset();
        push(4'b0010, 64'h4000);
        wait_req("to_a");
        chk_req_ready = 1'b1; tick(); chk_req_ready = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("to_a_err_early", 64'(err), 64'd0);
        chk_done_valid = 1'b1; tick(); chk_done_valid = 1'b0;
        chk("to_a_err", 64'(err), 64'd0);
        chk("to_a_cnt", 64'(commit_cnt), 64'd1);

        // No done at all: error the cycle after the 16th WAIT cycle
        push(4'b0010, 64'h4100);
        wait_req("to_b");
        chk_req_ready = 1'b1; tick(); chk_req_ready = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("to_b_err_early", 64'(err), 64'd0);
        tick();
        chk("to_b_err", 64'(err), 64'd1);
        chk("to_b_err_timeout", 64'(err_timeout), 64'd1);
        chk("to_b_err_hart", 64'(err_hart), 64'd1);
        chk_done_valid = 1'b1; tick(); chk_done_valid = 1'b0;
        chk("to_b_halt_cnt", 64'(commit_cnt), 64'd1);
        chk("to_b_halt_busy", 64'(busy), 64'd1);

        // Reset mid-WAIT with 3 entries queued
        do_reset();
        push(4'b0001, 64'h5000);
        push(4'b0111, 64'h5100);
        chk("rw_issue", 64'(chk_req_valid), 64'd1);
        chk_req_ready = 1'b1; tick(); chk_req_ready = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rw_valid", 64'(chk_req_valid), 64'd0);
        chk("rw_pc", chk_req_pc, 64'd0);
        chk("rw_ins", 64'(chk_req_ins), 64'd0);
        chk("rw_misc", {57'd0, chk_req_wr_valid, chk_req_dst, chk_req_hart}, 64'd0);
        chk("rw_data", chk_req_data, 64'd0);
        chk("rw_err", {61'd0, err, err_timeout, err_hart == 2'd0}, 64'd1);
        chk("rw_cnt", 64'(commit_cnt), 64'd0);
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_ready", 64'(commit_ready), 64'hF);
        chk_done_valid = 1'b1; tick(); chk_done_valid = 1'b0;
        chk("rw_stray_cnt", 64'(commit_cnt), 64'd0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (chk_req_valid || busy) seen++;
        end
        chk("rw_quiet", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
